// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the ALU command sequencer.
// Op codes are carried through the sequencer untouched; the enum only
// documents the encoding understood by the downstream ALU.
package alu_seq_pkg;

    localparam int unsigned ALU_SEQ_DATA_W = 8;
    localparam int unsigned ALU_OP_W       = 3;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_AND   = 3'b010,
        OP_OR    = 3'b011,
        OP_XOR   = 3'b100,
        OP_NOT   = 3'b101,
        OP_CMP   = 3'b110,
        OP_SHIFT = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_OUT  = 2'b10
    } seq_state_e;

    // Width of one queued command: operand A, operand B and op code.
    function automatic int unsigned cmd_width(input int unsigned data_w);
        return 2 * data_w + ALU_OP_W;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous command FIFO, power-of-two depth.
// Pushes while full are dropped without touching any state; pops while
// empty are ignored. Full/empty come straight from the registered count.
module alu_cmd_fifo
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = cmd_width(ALU_SEQ_DATA_W),
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: queues ALU commands, feeds them one at a time to a
// downstream combinational ALU through registered operands, and presents
// each captured result on a valid/ready output port.
// Optional feature macro: ALU_SEQ_STATS_EN adds saturating hand-off
// counters stat_cmds and stat_zeros.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned DATA_W = ALU_SEQ_DATA_W,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [2:0]        in_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_zero,
    output logic [2:0]        out_op
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [15:0]       stat_cmds,
    output logic [15:0]       stat_zeros
`endif
);

    localparam int unsigned CMD_W = cmd_width(DATA_W);

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [2:0]        op;
    } cmd_t;

    seq_state_e        r_state;
    seq_state_e        w_state_nxt;
    logic              w_pop;
    logic              w_capture;
    logic              w_handoff;

    cmd_t              w_fifo_wdata;
    cmd_t              w_head;
    logic              w_fifo_full;
    logic              w_fifo_empty;

    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [2:0]        r_alu_op;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_result;
    logic              r_out_zero;
    logic [2:0]        r_out_op;

    assign w_fifo_wdata = '{a: in_a, b: in_b, op: in_op};

    alu_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (in_valid),
        .i_data  (w_fifo_wdata),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign in_ready   = !w_fifo_full;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_op     = r_alu_op;
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_zero   = r_out_zero;
    assign out_op     = r_out_op;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-cycle strobes: pop, capture, output hand-off.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        w_handoff   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_capture   = 1'b1;
                w_state_nxt = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    w_handoff = 1'b1;
                    if (!w_fifo_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ST_EXEC;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ALU operand registers load only when a command leaves the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= '0;
        end else if (w_pop) begin
            r_alu_a  <= w_head.a;
            r_alu_b  <= w_head.b;
            r_alu_op <= w_head.op;
        end
    end

    // Result capture in EXEC; valid drops on the consumer hand-off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_zero   <= 1'b0;
            r_out_op     <= '0;
        end else if (w_capture) begin
            r_out_valid  <= 1'b1;
            r_out_result <= alu_result;
            r_out_zero   <= alu_zero;
            r_out_op     <= r_alu_op;
        end else if (w_handoff) begin
            r_out_valid  <= 1'b0;
        end
    end

`ifdef ALU_SEQ_STATS_EN
    logic [15:0] r_stat_cmds;
    logic [15:0] r_stat_zeros;

    assign stat_cmds  = r_stat_cmds;
    assign stat_zeros = r_stat_zeros;

    // Saturating counters of handed-off results and zero-flagged results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_cmds  <= '0;
            r_stat_zeros <= '0;
        end else if (w_handoff) begin
            if (r_stat_cmds != '1) begin
                r_stat_cmds <= r_stat_cmds + 16'd1;
            end
            if (r_out_zero && (r_stat_zeros != '1)) begin
                r_stat_zeros <= r_stat_zeros + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed bench for alu_cmd_sequencer with a small
// behavioural ALU downstream. Expected results are hand-computed constants.
module tb_alu_cmd_sequencer;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [2:0] in_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic       out_zero;
    logic [2:0] out_op;
`ifdef ALU_SEQ_STATS_EN
    logic [15:0] stat_cmds;
    logic [15:0] stat_zeros;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] res;
        logic       zero;
        logic [2:0] op;
    } exp_t;

    exp_t exp_q[$];

    alu_cmd_sequencer #(
        .DATA_W (8),
        .DEPTH  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_op     (out_op)
`ifdef ALU_SEQ_STATS_EN
        ,
        .stat_cmds  (stat_cmds),
        .stat_zeros (stat_zeros)
`endif
    );

    // Downstream combinational ALU (CMP = a<b, SHIFT = a<<b[2:0]).
    always_comb begin
        alu_result = '0;
        case (alu_op)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a - alu_b;
            3'b010:  alu_result = alu_a & alu_b;
            3'b011:  alu_result = alu_a | alu_b;
            3'b100:  alu_result = alu_a ^ alu_b;
            3'b101:  alu_result = ~alu_a;
            3'b110:  alu_result = (alu_a < alu_b) ? 8'd1 : 8'd0;
            default: alu_result = alu_a << alu_b[2:0];
        endcase
        alu_zero = (alu_result == 8'd0);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    // Offer one command and hold it until accepted (bounded wait).
    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        int w;
        w = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_op = op;
        while (!in_ready && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        check_eq("push_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Must be entered at a negedge; consumes n results from exp_q in order.
    task automatic drain_expect(input int n);
        int   got;
        int   cyc;
        exp_t e;
        got = 0;
        cyc = 0;
        out_ready = 1'b1;
        while (got < n && cyc < 20 * n) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("drain_extra", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("drain_res", out_result, e.res);
                    check_eq("drain_zero", out_zero, e.zero);
                    check_eq("drain_op", out_op, e.op);
                end
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        check_eq("drain_cnt", got, n);
    endtask

    // Single command into an idle block, checking the cycle-exact latency.
    task automatic run_one(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                           input logic [7:0] res, input logic zero);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_op = op;
        check_eq("one_rdy", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("one_v_n", out_valid, 0);
        @(negedge clk);
        check_eq("one_v_n1", out_valid, 0);
        check_eq("one_alu_a", alu_a, a);
        check_eq("one_alu_b", alu_b, b);
        check_eq("one_alu_op", alu_op, op);
        @(negedge clk);
        check_eq("one_v_n2", out_valid, 1);
        check_eq("one_res", out_result, res);
        check_eq("one_zero", out_zero, zero);
        check_eq("one_op", out_op, op);
        @(negedge clk);
        check_eq("one_v_n3", out_valid, 0);
    endtask

    logic [7:0] t4_a   [5] = '{8'h01, 8'hF0, 8'hF0, 8'h5A, 8'h10};
    logic [7:0] t4_b   [5] = '{8'h02, 8'h3C, 8'h0F, 8'h5A, 8'h01};
    logic [2:0] t4_op  [5] = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b001};
    logic [7:0] t4_res [5] = '{8'h03, 8'h30, 8'hFF, 8'h00, 8'h0F};

    logic [7:0] t6_a   [10] = '{8'h01, 8'h80, 8'h05, 8'hFF, 8'h00, 8'h3C, 8'h0F, 8'h03, 8'h01, 8'h09};
    logic [7:0] t6_b   [10] = '{8'h01, 8'h80, 8'h07, 8'h0F, 8'h00, 8'hC3, 8'h00, 8'h09, 8'h03, 8'h03};
    logic [2:0] t6_op  [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6};
    logic [7:0] t6_res [10] = '{8'h02, 8'h00, 8'hFE, 8'h0F, 8'h00, 8'hFF, 8'hF0, 8'h01, 8'h08, 8'h00};

    initial begin
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        out_ready = 1'b0;

        // Reset state.
        #3;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_alu", {alu_a, alu_b, 5'd0, alu_op}, 0);
        check_eq("rst_out", {out_result, 3'd0, out_zero, 1'b0, out_op}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic ADD and zero-producing SUB.
        run_one(8'd10, 8'd20, 3'b000, 8'h1E, 1'b0);
`ifdef ALU_SEQ_STATS_EN
        check_eq("stat_cmds_1", stat_cmds, 1);
        check_eq("stat_zeros_1", stat_zeros, 0);
`endif
        run_one(8'd15, 8'd15, 3'b001, 8'h00, 1'b1);
`ifdef ALU_SEQ_STATS_EN
        check_eq("stat_cmds_2", stat_cmds, 2);
        check_eq("stat_zeros_2", stat_zeros, 1);
`endif

        // AND then OR back-to-back: results two cycles apart.
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_a = 8'hAA;
        in_b = 8'h55;
        in_op = 3'b010;
        @(posedge clk);
        #1;
        in_op = 3'b011;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("ao_v1", out_valid, 0);
        @(negedge clk);
        check_eq("ao_v2", out_valid, 1);
        check_eq("ao_and_res", out_result, 8'h00);
        check_eq("ao_and_zero", out_zero, 1);
        @(negedge clk);
        check_eq("ao_v3", out_valid, 0);
        @(negedge clk);
        check_eq("ao_v4", out_valid, 1);
        check_eq("ao_or_res", out_result, 8'hFF);
        check_eq("ao_or_zero", out_zero, 0);
        check_eq("ao_or_op", out_op, 3'b011);
        @(negedge clk);
        check_eq("ao_v5", out_valid, 0);

        // Back-pressure: five pushes fill the block, sixth is dropped.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_a = t4_a[i];
            in_b = t4_b[i];
            in_op = t4_op[i];
            check_eq("fill_rdy", in_ready, 1);
            @(posedge clk);
            #1;
            exp_q.push_back('{res: t4_res[i], zero: (t4_res[i] == 8'h00), op: t4_op[i]});
        end
        check_eq("full_rdy", in_ready, 0);
        in_a = 8'h33;
        in_b = 8'h00;
        in_op = 3'b101;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_res", out_result, 8'h03);
            check_eq("hold_alu_a", alu_a, 8'h01);
            check_eq("hold_rdy", in_ready, 0);
        end
        in_valid = 1'b0;
        drain_expect(5);
        for (int i = 0; i < 4; i++) @(negedge clk);
        check_eq("no_extra", out_valid, 0);
        check_eq("empty_rdy", in_ready, 1);

        // Simultaneous push and pop with two queued keeps count at two.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_a = 8'h11; in_b = 8'h22; in_op = 3'b000;
        @(posedge clk); #1;
        in_a = 8'h44; in_b = 8'h04; in_op = 3'b001;
        @(posedge clk); #1;
        in_a = 8'h0F; in_b = 8'hF0; in_op = 3'b011;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("pp_a_valid", out_valid, 1);
        check_eq("pp_a_res", out_result, 8'h33);
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_a = 8'hAA; in_b = 8'hAA; in_op = 3'b100;
        check_eq("pp_rdy_d", in_ready, 1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("pp_cnt2", in_ready, 1);
        in_a = 8'h02; in_b = 8'h01; in_op = 3'b111;
        @(posedge clk); #1;
        check_eq("pp_cnt3", in_ready, 1);
        in_a = 8'hFF; in_b = 8'h00; in_op = 3'b101;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("pp_full", in_ready, 0);
        exp_q.push_back('{res: 8'h40, zero: 1'b0, op: 3'b001});
        exp_q.push_back('{res: 8'hFF, zero: 1'b0, op: 3'b011});
        exp_q.push_back('{res: 8'h00, zero: 1'b1, op: 3'b100});
        exp_q.push_back('{res: 8'h04, zero: 1'b0, op: 3'b111});
        exp_q.push_back('{res: 8'h00, zero: 1'b1, op: 3'b101});
        @(negedge clk);
        drain_expect(5);

        // Streaming ten commands: pointers wrap, order preserved.
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back('{res: t6_res[i], zero: (t6_res[i] == 8'h00), op: t6_op[i]});
        end
        @(negedge clk);
        fork
            begin
                for (int i = 0; i < 10; i++) push(t6_a[i], t6_b[i], t6_op[i]);
            end
            begin
                drain_expect(10);
            end
        join

        // Reset while a result is held and three commands are queued.
        @(negedge clk);
        out_ready = 1'b0;
        push(8'h01, 8'h01, 3'b000);
        push(8'h02, 8'h02, 3'b000);
        push(8'h03, 8'h03, 3'b000);
        push(8'h04, 8'h04, 3'b000);
        @(negedge clk);
        check_eq("mid_valid", out_valid, 1);
        check_eq("mid_res", out_result, 8'h02);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", out_valid, 0);
        check_eq("mid_rst_rdy", in_ready, 1);
        check_eq("mid_rst_alu_a", alu_a, 0);
        check_eq("mid_rst_res", out_result, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check_eq("post_rst_results", seen, 0);
        check_eq("post_rst_rdy", in_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
